series_adder_stream: RTL

SERIES_ADDER_STREAM -- requirements
Module: series_adder_stream

---
 rtl/series_adder_stream.sv | 121 ++++++++++++
 1 files changed

// File: rtl/series_adder_stream.sv
// Streaming multi-word adder/subtractor: a header gives the word count N, then
// operand pairs A,B are summed DIGIT_W bits per cycle with the carry chained across words.
module series_adder_stream #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DIGIT_W = 8,
  parameter int unsigned LEN_W   = 16
) (
  input  logic              clk,
  input  logic              rst_p,
  input  logic              op_sub,
  input  logic              data_vld,
  input  logic [DATA_W-1:0] data_i,
  output logic              data_rdy,
  output logic              module_idle,
  output logic [DATA_W-1:0] result_o,
  output logic              result_vld,
  input  logic              result_rdy,
  output logic              result_first,
  output logic              result_last,
  output logic              carry_o
);

  localparam int unsigned D     = DATA_W / DIGIT_W;
  localparam int unsigned CNT_W = (D > 1) ? $clog2(D) : 1;

  typedef enum logic [2:0] {IDLE, GET_A, GET_B, CALC, OUT} state_t;

  state_t              state, state_nxt;
  logic [LEN_W-1:0]    n_q, idx_q;
  logic                sub_q, carry_q;
  logic [DATA_W-1:0]   a_q, b_q, res_q, res_nxt;
  logic [CNT_W-1:0]    cnt_q;
  logic [DIGIT_W:0]    digit_sum;
  logic                xfer, hs, last_digit, last_word;

  assign data_rdy    = !rst_p && (state == IDLE || state == GET_A || state == GET_B);
  assign xfer        = data_vld && data_rdy;
  assign hs          = result_vld && result_rdy;
  assign module_idle = (state == IDLE);
  assign last_digit  = (cnt_q == CNT_W'(D - 1));
  assign last_word   = (idx_q == LEN_W'(n_q - 1'b1));

  // One digit of the ripple: B is inverted and the carry preloaded with 1 for subtraction.
  assign digit_sum = {1'b0, a_q[DIGIT_W-1:0]}
                   + {1'b0, b_q[DIGIT_W-1:0] ^ {DIGIT_W{sub_q}}}
                   + (DIGIT_W + 1)'(carry_q);
  assign res_nxt   = DATA_W'({digit_sum[DIGIT_W-1:0], res_q} >> DIGIT_W);

  always_ff @(posedge clk) begin
    if (rst_p) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer && data_i[LEN_W-1:0] != '0) state_nxt = GET_A;
      GET_A:   if (xfer) state_nxt = GET_B;
      GET_B:   if (xfer) state_nxt = CALC;
      CALC:    if (last_digit) state_nxt = OUT;
      OUT:     if (hs) state_nxt = result_last ? IDLE : GET_A;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_p) begin
      n_q          <= '0;
      idx_q        <= '0;
      sub_q        <= 1'b0;
      carry_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      cnt_q        <= '0;
      result_o     <= '0;
      result_vld   <= 1'b0;
      result_first <= 1'b0;
      result_last  <= 1'b0;
      carry_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (xfer) begin
          n_q     <= data_i[LEN_W-1:0];
          sub_q   <= op_sub;
          carry_q <= op_sub;
          idx_q   <= '0;
        end
        GET_A: if (xfer) a_q <= data_i;
        GET_B: if (xfer) begin
          b_q   <= data_i;
          cnt_q <= '0;
        end
        CALC: begin
          carry_q <= digit_sum[DIGIT_W];
          a_q     <= a_q >> DIGIT_W;
          b_q     <= b_q >> DIGIT_W;
          res_q   <= res_nxt;
          cnt_q   <= cnt_q + 1'b1;
          // Final digit: publish the word and its framing flags together.
          if (last_digit) begin
            result_o     <= res_nxt;
            result_vld   <= 1'b1;
            result_first <= (idx_q == '0);
            result_last  <= last_word;
            carry_o      <= last_word & digit_sum[DIGIT_W];
          end
        end
        OUT: if (hs) begin
          result_vld   <= 1'b0;
          result_first <= 1'b0;
          result_last  <= 1'b0;
          carry_o      <= 1'b0;
          if (!result_last) idx_q <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
